// File: rtl/pe_feed_pkg.sv
// Shared types and constants for the serial_pe feed controller.
package pe_feed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FILL   = 2'd2,
        ST_STREAM = 2'd3
    } feed_state_t;

    localparam int DEF_ELEM_W     = 16;
    localparam int DEF_LINE_ELEMS = 32;

    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

endpackage

// File: rtl/pe_line_serializer.sv
// Current/next line registers and element mux; element 0 is the line's MSBs.
module pe_line_serializer
    import pe_feed_pkg::*;
#(
    parameter int ELEM_W     = DEF_ELEM_W,
    parameter int LINE_ELEMS = DEF_LINE_ELEMS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_cur,
    input  logic                         load_nxt,
    input  logic                         advance,
    input  logic [ELEM_W*LINE_ELEMS-1:0] neuron_line,
    input  logic [ELEM_W*LINE_ELEMS-1:0] weight_line,
    output logic                         first_elem,
    output logic                         last_elem,
    output logic [ELEM_W-1:0]            neuron_elem,
    output logic [ELEM_W-1:0]            weight_elem
);

    localparam int LINE_W = ELEM_W * LINE_ELEMS;
    localparam int IDX_W  = (LINE_ELEMS > 1) ? $clog2(LINE_ELEMS) : 1;

    logic [LINE_W-1:0] cur_n_reg, cur_w_reg;
    logic [LINE_W-1:0] nxt_n_reg, nxt_w_reg;
    logic [IDX_W-1:0]  idx_reg;

    logic [ELEM_W-1:0] n_elems [LINE_ELEMS];
    logic [ELEM_W-1:0] w_elems [LINE_ELEMS];

    assign first_elem = (idx_reg == '0);
    assign last_elem  = (idx_reg == IDX_W'(LINE_ELEMS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_n_reg <= '0;
            cur_w_reg <= '0;
            nxt_n_reg <= '0;
            nxt_w_reg <= '0;
            idx_reg   <= '0;
        end else begin
            if (load_nxt) begin
                nxt_n_reg <= neuron_line;
                nxt_w_reg <= weight_line;
            end
            if (load_cur) begin
                cur_n_reg <= neuron_line;
                cur_w_reg <= weight_line;
                idx_reg   <= '0;
            end else if (advance) begin
                // Index wraps naturally because LINE_ELEMS is a power of two.
                idx_reg <= idx_reg + 1'b1;
                if (last_elem) begin
                    cur_n_reg <= nxt_n_reg;
                    cur_w_reg <= nxt_w_reg;
                end
            end
        end
    end

    for (genvar gi = 0; gi < LINE_ELEMS; gi++) begin : g_split
        assign n_elems[gi] = cur_n_reg[ELEM_W*(LINE_ELEMS-1-gi) +: ELEM_W];
        assign w_elems[gi] = cur_w_reg[ELEM_W*(LINE_ELEMS-1-gi) +: ELEM_W];
    end

    assign neuron_elem = n_elems[idx_reg];
    assign weight_elem = w_elems[idx_reg];

endmodule

// File: rtl/pe_feed_ctrl.sv
// Streaming initiator for serial_pe: instruction intake, line fetch/prefetch, PE framing.
// Optional performance counters are enabled by defining PE_FEED_PERF_EN.
module pe_feed_ctrl
    import pe_feed_pkg::*;
#(
    parameter int ELEM_W     = DEF_ELEM_W,
    parameter int LINE_ELEMS = DEF_LINE_ELEMS,
    parameter int LADDR_W    = 11,
    parameter int LEN_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inst_valid,
    output logic                         inst_ready,
    input  logic [LEN_W-1:0]             inst_len,
    output logic                         mem_rd_en,
    output logic [LADDR_W-1:0]           mem_rd_addr,
    input  logic [ELEM_W*LINE_ELEMS-1:0] neuron_line,
    input  logic [ELEM_W*LINE_ELEMS-1:0] weight_line,
    output logic [ELEM_W-1:0]            pe_neuron,
    output logic [ELEM_W-1:0]            pe_weight,
    output logic [1:0]                   pe_ctl,
    output logic                         pe_vld,
    output logic                         inst_done,
    output logic                         len_err,
    output logic [31:0]                  busy_cnt,
    output logic [31:0]                  bubble_cnt
);

    feed_state_t        state_reg;
    logic [LADDR_W-1:0] line_ptr_reg;
    logic               pend_valid_reg;
    logic [LEN_W-1:0]   pend_len_reg;
    logic [LEN_W-1:0]   lines_left_reg;
    logic               first_reg;
    logic               nxt_next_reg;
    logic               mem_rd_en_reg;
    logic [LADDR_W-1:0] mem_rd_addr_reg;
    logic               rd_dly_reg;
    logic               len_err_reg;

    logic               ser_first, ser_last;
    logic [ELEM_W-1:0]  ser_neuron, ser_weight;

    logic streaming, hs, at_last_line, inst_end, prefetch, start_idle, dequeue;

    assign inst_ready   = !pend_valid_reg;
    assign hs           = inst_valid && inst_ready;
    assign streaming    = (state_reg == ST_STREAM);
    assign at_last_line = (lines_left_reg == '0);
    assign inst_end     = streaming && ser_last && at_last_line;
    // Zero-length instructions never enter the pending slot, so any pending entry has N != 0.
    assign prefetch     = streaming && ser_first && (!at_last_line || pend_valid_reg);
    assign start_idle   = (state_reg == ST_IDLE) && pend_valid_reg;
    assign dequeue      = start_idle || (inst_end && nxt_next_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            line_ptr_reg    <= '0;
            pend_valid_reg  <= 1'b0;
            pend_len_reg    <= '0;
            lines_left_reg  <= '0;
            first_reg       <= 1'b0;
            nxt_next_reg    <= 1'b0;
            mem_rd_en_reg   <= 1'b0;
            mem_rd_addr_reg <= '0;
            rd_dly_reg      <= 1'b0;
            len_err_reg     <= 1'b0;
        end else begin
            len_err_reg   <= hs && (inst_len == '0);
            rd_dly_reg    <= mem_rd_en_reg && streaming;
            mem_rd_en_reg <= 1'b0;

            if (hs && (inst_len != '0)) begin
                pend_valid_reg <= 1'b1;
                pend_len_reg   <= inst_len;
            end else if (dequeue) begin
                pend_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (pend_valid_reg) begin
                        state_reg       <= ST_LOAD;
                        mem_rd_en_reg   <= 1'b1;
                        mem_rd_addr_reg <= line_ptr_reg;
                        line_ptr_reg    <= line_ptr_reg + 1'b1;
                        lines_left_reg  <= pend_len_reg - 1'b1;
                    end
                end
                ST_LOAD: state_reg <= ST_FILL;
                ST_FILL: begin
                    state_reg <= ST_STREAM;
                    first_reg <= 1'b1;
                end
                ST_STREAM: begin
                    first_reg <= 1'b0;
                    if (prefetch) begin
                        mem_rd_en_reg   <= 1'b1;
                        mem_rd_addr_reg <= line_ptr_reg;
                        line_ptr_reg    <= line_ptr_reg + 1'b1;
                        nxt_next_reg    <= at_last_line;
                    end
                    if (ser_last) begin
                        if (!at_last_line) begin
                            lines_left_reg <= lines_left_reg - 1'b1;
                        end else if (nxt_next_reg) begin
                            // Next instruction's first line is already in nxt: continue without a gap.
                            lines_left_reg <= pend_len_reg - 1'b1;
                            first_reg      <= 1'b1;
                            nxt_next_reg   <= 1'b0;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    pe_line_serializer #(
        .ELEM_W     (ELEM_W),
        .LINE_ELEMS (LINE_ELEMS)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_cur    (state_reg == ST_FILL),
        .load_nxt    (rd_dly_reg),
        .advance     (streaming),
        .neuron_line (neuron_line),
        .weight_line (weight_line),
        .first_elem  (ser_first),
        .last_elem   (ser_last),
        .neuron_elem (ser_neuron),
        .weight_elem (ser_weight)
    );

    assign mem_rd_en         = mem_rd_en_reg;
    assign mem_rd_addr       = mem_rd_addr_reg;
    assign pe_vld            = streaming;
    assign pe_neuron         = streaming ? ser_neuron : '0;
    assign pe_weight         = streaming ? ser_weight : '0;
    assign pe_ctl[CTL_FIRST] = streaming && first_reg;
    assign pe_ctl[CTL_LAST]  = inst_end;
    assign inst_done         = inst_end;
    assign len_err           = len_err_reg;

`ifdef PE_FEED_PERF_EN
    logic [31:0] busy_cnt_reg, bubble_cnt_reg;
    logic        bubble_evt;

    assign bubble_evt = (state_reg == ST_LOAD) || (state_reg == ST_FILL) ||
                        ((state_reg == ST_IDLE) && pend_valid_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_reg   <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (streaming && (busy_cnt_reg != '1))
                busy_cnt_reg <= busy_cnt_reg + 1'b1;
            if (bubble_evt && (bubble_cnt_reg != '1))
                bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
        end
    end

    assign busy_cnt   = busy_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;
`else
    assign busy_cnt   = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Self-checking bench for pe_feed_ctrl: element-stream scoreboard plus directed timing checks.
module tb_pe_feed_ctrl;
    import pe_feed_pkg::*;

    localparam int ELEM_W     = 16;
    localparam int LINE_ELEMS = 32;
    localparam int LADDR_W    = 8;
    localparam int LEN_W      = 8;
    localparam int LINE_W     = ELEM_W * LINE_ELEMS;
    localparam int NLINES     = 1 << LADDR_W;
`ifdef PE_FEED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               inst_valid;
    logic               inst_ready;
    logic [LEN_W-1:0]   inst_len;
    logic               mem_rd_en;
    logic [LADDR_W-1:0] mem_rd_addr;
    logic [LINE_W-1:0]  neuron_line;
    logic [LINE_W-1:0]  weight_line;
    logic [ELEM_W-1:0]  pe_neuron, pe_weight;
    logic [1:0]         pe_ctl;
    logic               pe_vld, inst_done, len_err;
    logic [31:0]        busy_cnt, bubble_cnt;

    always #5 clk = ~clk;

    pe_feed_ctrl #(
        .ELEM_W(ELEM_W), .LINE_ELEMS(LINE_ELEMS), .LADDR_W(LADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_len(inst_len), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .neuron_line(neuron_line), .weight_line(weight_line), .pe_neuron(pe_neuron),
        .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld(pe_vld), .inst_done(inst_done),
        .len_err(len_err), .busy_cnt(busy_cnt), .bubble_cnt(bubble_cnt)
    );

    // Line memory contents: neuron element e of line a = a*32+e+1, weight = neuron ^ 0xA5A5.
    function automatic logic [ELEM_W-1:0] nval(int a, int e);
        return ELEM_W'(a * LINE_ELEMS + e + 1);
    endfunction

    function automatic logic [ELEM_W-1:0] wval(int a, int e);
        return nval(a, e) ^ 16'hA5A5;
    endfunction

    function automatic logic [LINE_W-1:0] make_line(int a, bit wt);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int e = 0; e < LINE_ELEMS; e++)
            l[ELEM_W*(LINE_ELEMS-1-e) +: ELEM_W] = wt ? wval(a, e) : nval(a, e);
        return l;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) begin
            neuron_line <= make_line(int'(mem_rd_addr), 1'b0);
            weight_line <= make_line(int'(mem_rd_addr), 1'b1);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural model: each accepted instruction of N lines contributes N consecutive
    // line addresses and N*LINE_ELEMS elements, in acceptance order.
    typedef struct {
        logic [ELEM_W-1:0] n;
        logic [ELEM_W-1:0] w;
        logic              first;
        logic              last;
    } exp_t;

    exp_t exp_q[$];
    int   addr_q[$];
    int   model_ptr;
    int   exp_len_err_cyc;

    int   vld_count, first_vld_cyc, last_vld_cyc;
    int   rd_log[$], rd_cyc_log[$], start_cyc_log[$], done_cyc_log[$];
    logic [ELEM_W-1:0] first_n_log[$], done_n_log[$];

    task automatic clear_logs();
        exp_q.delete(); addr_q.delete();
        rd_log.delete(); rd_cyc_log.delete(); start_cyc_log.delete(); done_cyc_log.delete();
        first_n_log.delete(); done_n_log.delete();
        model_ptr = 0; exp_len_err_cyc = -1;
        vld_count = 0; first_vld_cyc = -1; last_vld_cyc = -1;
    endtask

    task automatic model_accept(input int n);
        for (int l = 0; l < n; l++) begin
            int a;
            a = (model_ptr + l) % NLINES;
            addr_q.push_back(a);
            for (int e = 0; e < LINE_ELEMS; e++) begin
                exp_t x;
                x.n = nval(a, e);
                x.w = wval(a, e);
                x.first = (l == 0) && (e == 0);
                x.last  = (l == n - 1) && (e == LINE_ELEMS - 1);
                exp_q.push_back(x);
            end
        end
        model_ptr = (model_ptr + n) % NLINES;
    endtask

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (pe_vld) begin
                vld_count++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                last_vld_cyc = cyc;
                if (pe_ctl[CTL_FIRST]) begin
                    start_cyc_log.push_back(cyc);
                    first_n_log.push_back(pe_neuron);
                end
                if (inst_done) begin
                    done_cyc_log.push_back(cyc);
                    done_n_log.push_back(pe_neuron);
                end
                if (exp_q.size() == 0) begin
                    check("unexpected pe_vld", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    check("stream element {neuron,weight,ctl,done}",
                          {pe_neuron, pe_weight, pe_ctl, inst_done},
                          {x.n, x.w, x.last, x.first, x.last});
                end
            end else begin
                check("idle outputs zero", {pe_neuron, pe_weight, pe_ctl, inst_done}, 0);
            end
            if (mem_rd_en) begin
                rd_log.push_back(int'(mem_rd_addr));
                rd_cyc_log.push_back(cyc);
                if (addr_q.size() == 0) check("unexpected mem_rd_en", 1, 0);
                else check("mem_rd_addr", mem_rd_addr, addr_q.pop_front());
            end
            check("len_err", len_err, (cyc == exp_len_err_cyc));
        end
    end

    task automatic send(input int n, output int hs_cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        inst_valid = 1'b1;
        inst_len   = LEN_W'(n);
        while (!inst_ready && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (!inst_ready) check("inst_ready timeout", 0, 1);
        @(posedge clk);
        #1;
        hs_cyc     = cyc;
        inst_valid = 1'b0;
        inst_len   = '0;
        if (n == 0) exp_len_err_cyc = hs_cyc;
        else model_accept(n);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("stream drained within budget", (exp_q.size() == 0) && (addr_q.size() == 0), 1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic wait_vld(input int target);
        int k;
        k = 0;
        while (vld_count < target && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("pe_vld count reached", vld_count >= target, 1);
    endtask

    task automatic check_reset_state();
        check("reset ctl {ready,vld,ctl,done,len_err,rd_en,addr}",
              {inst_ready, pe_vld, pe_ctl, inst_done, len_err, mem_rd_en, mem_rd_addr}, 15'h4000);
        check("reset data", {pe_neuron, pe_weight}, 0);
        check("reset counters", {busy_cnt, bubble_cnt}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_logs();
        #1;
        check_reset_state();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int hs;
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst_len   = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        #1;
        rst_n = 1'b1;

        // Single N=1 instruction: latency and framing.
        send(1, hs);
        wait_drain(200);
        check("t1 mem_rd_en cycle", rd_cyc_log[0], hs + 1);
        check("t1 first pe_vld cycle", start_cyc_log[0], hs + 3);
        check("t1 first neuron", first_n_log[0], 16'h0001);
        check("t1 done neuron", done_n_log[0], 16'h0020);
        check("t1 done cycle", done_cyc_log[0], hs + 3 + 31);
        check("t1 vld count", vld_count, 32);
        check("t1 busy_cnt", busy_cnt, PERF ? 32 : 0);
        check("t1 bubble_cnt", bubble_cnt, PERF ? 3 : 0);

        // Four instructions 4,3,2,1 back to back.
        do_reset();
        send(4, hs); send(3, hs); send(2, hs); send(1, hs);
        wait_drain(1000);
        check("t2 vld count", vld_count, 320);
        check("t2 gapless span", last_vld_cyc - first_vld_cyc + 1, 320);
        check("t2 done pulses", done_cyc_log.size(), 4);
        for (int k = 0; k < 3; k++)
            check("t2 back-to-back start", start_cyc_log[k+1], done_cyc_log[k] + 1);
        check("t2 last rd addr", rd_log[9], 9);
        check("t2 busy_cnt", busy_cnt, PERF ? 320 : 0);
        check("t2 bubble_cnt", bubble_cnt, PERF ? 3 : 0);

        // Late second instruction: costs IDLE, LOAD, FILL.
        do_reset();
        send(2, hs);
        wait_vld(33);
        repeat (5) @(negedge clk);
        send(2, hs);
        wait_drain(500);
        check("t3 done pulses", done_cyc_log.size(), 2);
        check("t3 gap cycles", start_cyc_log[1] - done_cyc_log[0] - 1, 3);
        check("t3 second stream line 2", rd_log[2], 2);
        check("t3 second stream line 3", rd_log[3], 3);
        check("t3 second first neuron", first_n_log[1], nval(2, 0));
        check("t3 bubble_cnt", bubble_cnt, PERF ? 6 : 0);

        // Zero-length instruction: error pulse only, no read, pointer unchanged.
        do_reset();
        send(0, hs);
        repeat (6) @(negedge clk);
        check("t4 no read for N=0", rd_log.size(), 0);
        send(1, hs);
        wait_drain(200);
        check("t4 next reads line 0", rd_log[0], 0);
        check("t4 next first neuron", first_n_log[0], 16'h0001);
        check("t4 bubble_cnt", bubble_cnt, PERF ? 3 : 0);

        // Address wrap across an N=255 instruction followed by N=3.
        do_reset();
        send(255, hs); send(3, hs);
        wait_drain(9000);
        check("t5 rd addr before wrap", rd_log[255], 255);
        check("t5 rd addr after wrap", rd_log[256], 0);
        check("t5 vld count", vld_count, 258 * 32);
        check("t5 gapless span", last_vld_cyc - first_vld_cyc + 1, 258 * 32);
        check("t5 busy_cnt", busy_cnt, PERF ? 258 * 32 : 0);

        // Reset mid-stream at element 17, then a fresh instruction from line 0.
        do_reset();
        send(2, hs);
        wait_vld(18);
        check("t6 element 17 neuron", pe_neuron, 16'h0012);
        rst_n = 1'b0;
        clear_logs();
        #1;
        check_reset_state();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        send(1, hs);
        wait_drain(200);
        check("t6 post-reset read line", rd_log[0], 0);
        check("t6 post-reset first neuron", first_n_log[0], 16'h0001);
        check("t6 post-reset done pulses", done_cyc_log.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_feed_ctrl.md
# pe_feed_ctrl

Streaming initiator for `serial_pe`. It accepts 8-bit length instructions over a valid/ready handshake and fetches 512-bit neuron and weight lines from two synchronous line memories. It serializes each line into 16-bit elements, one pair per cycle. It drives the PE's `vld_i` and `ctl[1:0]` first/last markers, so it is the synthesizable replacement for the bench-side stream generator in front of the PE.

## Interface
- `ELEM_W`, default 16: element width.
- `LINE_ELEMS`, default 32: elements per line; must be a power of 2.
- `LADDR_W`, default 11: line address width.
- `LEN_W`, default 8: instruction length field width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `inst_valid`  in  1  instruction offered.
- `inst_ready`  out  1  instruction slot free.
- `inst_len`  in  LEN_W  number of lines N in this instruction.
- `mem_rd_en`  out  1  read strobe, shared by both memories.
- `mem_rd_addr`  out  LADDR_W  line address.
- `neuron_line`  in  ELEM_W*LINE_ELEMS  neuron line read data; valid the cycle after `mem_rd_en`.
- `weight_line`  in  ELEM_W*LINE_ELEMS  weight line read data; same timing.
- `pe_neuron`  out  ELEM_W  neuron element to the PE.
- `pe_weight`  out  ELEM_W  weight element to the PE.
- `pe_ctl`  out  2  [0] first element of an instruction, [1] last element of an instruction.
- `pe_vld`  out  1  element valid.
- `inst_done`  out  1  one-cycle pulse with the last element.
- `len_err`  out  1  one-cycle pulse when an instruction with N=0 is accepted.
- `busy_cnt`  out  32  cycles with `pe_vld`=1.
- `bubble_cnt`  out  32  gap cycles; see Configuration.

## Operation
- One-entry pending register. `inst_ready = !pend_valid`. A handshake loads the pending register.
- N=0 is consumed without streaming and pulses `len_err` the following cycle.
- FSM states:
  - IDLE: when a pending instruction exists, go to LOAD.
  - LOAD: issue a read at `line_ptr`, then go to FILL.
  - FILL: capture both lines into `cur`, then go to STREAM.
  - STREAM: emit elements.
- In STREAM, element index `e` counts 0..LINE_ELEMS-1.
- Element e is taken from bits `[ELEM_W*(LINE_ELEMS-1-e) +: ELEM_W]`, so element 0 is the MSBs.
- `line_ptr` increments on every read. It is never reset between instructions: instructions consume consecutive lines, and the address wraps modulo 2^LADDR_W silently.
- Prefetch: at e==0 of each line, issue a read if either condition holds:
  - more lines remain in this instruction, or
  - it is the last line and a pending instruction with N≠0 exists.
- Prefetched data is captured into `nxt` one cycle later. At e==LINE_ELEMS-1, `cur <= nxt`.
- `pe_ctl[0]` = 1 on the first element of an instruction.
- `pe_ctl[1]` = 1 on the last element of the last line. `inst_done` is asserted in the same cycle.
- With N=1, `pe_ctl[0]` and `pe_ctl[1]` assert on different elements of the same line.
- At an instruction's last element:
  - if the next instruction was prefetched, go back-to-back: its first element follows in the next cycle and the FSM stays in STREAM;
  - otherwise go to IDLE.
- The pending register is dequeued when an instruction starts: at LOAD entry, or at a back-to-back transition.
- `pe_neuron`, `pe_weight` and `pe_ctl` are zero whenever `pe_vld`=0.

## Timing
- Reset values: all outputs 0 except `inst_ready`=1. `line_ptr`=0, state IDLE.
- Start latency: handshake at edge T → `mem_rd_en` in cycle T+1 → data captured at the end of T+2 → first `pe_vld` in cycle T+3.
- An instruction of N lines produces exactly N*LINE_ELEMS consecutive `pe_vld` cycles with no internal gaps.
- Back-to-back needs the next handshake to complete no later than the cycle before the last line's e==0. A later arrival costs a 3-cycle gap: IDLE, LOAD, FILL.
- A handshake in the same cycle as a dequeue is legal. `inst_ready` is combinational on `pend_valid` only.
- An asynchronous reset mid-stream aborts immediately. There is no partial `inst_done`, and the PE must also be reset.

## Configuration
- `PE_FEED_PERF_EN` defined:
  - `busy_cnt` increments on `pe_vld`.
  - `bubble_cnt` increments on cycles in LOAD/FILL or IDLE while `pend_valid`=1.
  - Both counters saturate at 0xFFFFFFFF.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Structure
- A shared package `pe_feed_pkg` holds:
  - the FSM state enum,
  - the `LINE_ELEMS`/`ELEM_W` defaults,
  - the `ctl` bit index constants `CTL_FIRST=0` and `CTL_LAST=1`.
- Single sub-module `pe_line_serializer`: the `cur`/`nxt` line registers, the element index and the element mux. The FSM and address logic stay in `pe_feed_ctrl`.

## Test plan
- Reset, then one instruction N=1 with line 0 holding elements 0x0001..0x0020 → 32 `pe_vld` cycles starting at T+3, `pe_neuron`=0x0001 first, ctl=01 then 00…, ctl=10 plus `inst_done` on 0x0020.
- Four instructions 4,3,2,1 offered continuously → 320 gapless `pe_vld` cycles, `mem_rd_addr` 0..9, exactly four `pe_ctl[1]` pulses, `bubble_cnt`=3 (initial fill only).
- N=2, then a second instruction offered 5 cycles after the first's last-line e==0 → exactly a 3-cycle gap, second stream reads lines 2..3.
- `inst_len`=0 → `len_err` pulse, no `mem_rd_en`, `line_ptr` unchanged, and the next instruction proceeds normally.
- `line_ptr` preloaded near 2^LADDR_W-1 by running N=255 instructions → address wraps to 0, no glitch in `pe_vld`.
- `rst_n` asserted at element 17 of a line → all outputs 0 in the same cycle. After release, a new N=1 instruction reads line 0.
